// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter and fetch sequencer with bounded fetch range
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_addr,
    input  logic        halt_req,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        fault,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    // One bit wider than the PC so the limit itself is representable for any IMEM_WORDS.
    localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

    state_t      state;
    state_t      next_state;
    logic [31:0] next_pc;
    logic [31:0] candidate_pc;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic [31:0] branch_offset;
    logic        retire_inc;
    logic        out_of_range;

    assign pc_plus4      = pc + 32'd4;
    assign jump_target   = {pc_plus4[31:28], jump_addr, 2'b00};
    assign branch_offset = {{14{branch_imm[15]}}, branch_imm, 2'b00};
    assign branch_target = pc_plus4 + branch_offset;

    // Jump outranks branch; stall and halt are resolved in the state logic.
    always_comb begin
        candidate_pc = pc_plus4;
        if (jump) begin
            candidate_pc = jump_target;
        end else if (branch) begin
            candidate_pc = branch_target;
        end
    end

    assign out_of_range = ({1'b0, candidate_pc} >= PC_LIMIT);

    always_comb begin
        next_state = state;
        next_pc    = pc;
        retire_inc = 1'b0;
        unique case (state)
            ST_BOOT: begin
                next_state = ST_RUN;
            end
            ST_RUN: begin
                if (halt_req) begin
                    next_state = ST_HALT;
                end else if (stall) begin
                    next_state = ST_RUN;
                end else if (out_of_range) begin
                    next_state = ST_FAULT;
                end else begin
                    next_pc    = candidate_pc;
                    retire_inc = 1'b1;
                end
            end
            ST_HALT: begin
                next_state = ST_HALT;
            end
            ST_FAULT: begin
                next_state = ST_FAULT;
            end
            default: begin
                next_state = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_BOOT;
            pc      <= RESET_PC;
            retired <= 32'd0;
        end else begin
            state   <= next_state;
            pc      <= next_pc;
            if (retire_inc) begin
                retired <= retired + 32'd1;
            end
        end
    end

    assign fetch_valid = (state == ST_RUN);
    assign fault       = (state == ST_FAULT);

endmodule
